svo_tmds_hdmi_enc: RTL



---
 rtl/svo_tmds_pkg.sv | 41 ++++
 rtl/svo_tmds_lane.sv | 88 ++++++++
 rtl/svo_tmds_hdmi_enc.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/svo_tmds_pkg.sv
// Shared constants and types for the SVO TMDS/HDMI encoder.
//   - TMDS control-period symbols, one per {c1, c0} pair
//   - HDMI video leading guard-band symbols, per lane
//   - seg_e: classification of each output cycle
//   - tmds_ones(): population count of a byte
//   - ctrl_code(): map a 2-bit control pair to its 10-bit symbol
package svo_tmds_pkg;

  // Symbols written MSB-first; bit 0 is serialised first.
  localparam logic [9:0] CtrlCode00 = 10'b1101010100;
  localparam logic [9:0] CtrlCode01 = 10'b0010101011;
  localparam logic [9:0] CtrlCode10 = 10'b0101010100;
  localparam logic [9:0] CtrlCode11 = 10'b1010101011;

  localparam logic [9:0] GuardCodeL0 = 10'b1011001100;
  localparam logic [9:0] GuardCodeL1 = 10'b0100110011;
  localparam logic [9:0] GuardCodeL2 = 10'b1011001100;

  typedef enum logic [1:0] {SEG_CTRL, SEG_PRE, SEG_GUARD, SEG_VIDEO} seg_e;

  function automatic logic [3:0] tmds_ones(input logic [7:0] d);
    logic [3:0] n;
    n = '0;
    for (int i = 0; i < 8; i++) begin
      n = n + {3'b000, d[i]};
    end
    return n;
  endfunction

  function automatic logic [9:0] ctrl_code(input logic [1:0] c);
    logic [9:0] code;
    case (c)
      2'b00:   code = CtrlCode00;
      2'b01:   code = CtrlCode01;
      2'b10:   code = CtrlCode10;
      default: code = CtrlCode11;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/svo_tmds_lane.sv
// One TMDS lane: two-stage DVI 8b/10b encoder with running-disparity register.
//   clk_i    pixel clock
//   rst_ni   synchronous active-low reset
//   seg_i    segment of the cycle being encoded (CTRL/PRE/GUARD/VIDEO)
//   ctrl_i   control pair to emit during CTRL/PRE
//   guard_i  guard-band symbol for this lane (static per lane)
//   data_i   pixel byte, used during VIDEO
//   dout_o   registered 10-bit symbol, two cycles after the inputs
module svo_tmds_lane
  import svo_tmds_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_ni,
  input  seg_e       seg_i,
  input  logic [1:0] ctrl_i,
  input  logic [9:0] guard_i,
  input  logic [7:0] data_i,
  output logic [9:0] dout_o
);

  // Stage 1: transition minimisation.
  logic [3:0] din_ones;
  logic       use_xnor;
  logic [8:0] qm_d, qm_q;
  seg_e       seg_q;
  logic [1:0] ctrl_q;

  always_comb begin
    din_ones = tmds_ones(data_i);
    use_xnor = (din_ones > 4'd4) || ((din_ones == 4'd4) && !data_i[0]);
    qm_d     = '0;
    qm_d[0]  = data_i[0];
    for (int i = 1; i < 8; i++) begin
      qm_d[i] = use_xnor ? ~(qm_d[i-1] ^ data_i[i]) : (qm_d[i-1] ^ data_i[i]);
    end
    qm_d[8] = ~use_xnor;
  end

  // Stage 2: DC balance against the running disparity.
  logic [3:0]        qm_ones;
  int                bal;    // ones minus zeros in qm_q[7:0]
  int                cnt_i;
  logic [9:0]        dout_d, dout_q;
  logic signed [4:0] cnt_d, cnt_q;

  always_comb begin
    qm_ones = tmds_ones(qm_q[7:0]);
    bal     = 2 * int'(qm_ones) - 8;
    cnt_i   = int'(cnt_q);
    dout_d  = ctrl_code(ctrl_q);
    cnt_d   = '0;
    unique case (seg_q)
      SEG_VIDEO: begin
        if ((cnt_i == 0) || (bal == 0)) begin
          dout_d = {~qm_q[8], qm_q[8], qm_q[8] ? qm_q[7:0] : ~qm_q[7:0]};
          cnt_d  = qm_q[8] ? 5'(cnt_i + bal) : 5'(cnt_i - bal);
        end else if (((cnt_i > 0) && (bal > 0)) || ((cnt_i < 0) && (bal < 0))) begin
          dout_d = {1'b1, qm_q[8], ~qm_q[7:0]};
          cnt_d  = 5'(cnt_i + 2 * int'(qm_q[8]) - bal);
        end else begin
          dout_d = {1'b0, qm_q[8], qm_q[7:0]};
          cnt_d  = 5'(cnt_i - 2 * int'(!qm_q[8]) + bal);
        end
      end
      SEG_GUARD: dout_d = guard_i;
      SEG_CTRL, SEG_PRE: dout_d = ctrl_code(ctrl_q);
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      qm_q   <= '0;
      seg_q  <= SEG_CTRL;
      ctrl_q <= 2'b00;
      dout_q <= CtrlCode00;
      cnt_q  <= '0;
    end else begin
      qm_q   <= qm_d;
      seg_q  <= seg_i;
      ctrl_q <= ctrl_i;
      dout_q <= dout_d;
      cnt_q  <= cnt_d;
    end
  end

  assign dout_o = dout_q;

endmodule

// File: rtl/svo_tmds_hdmi_enc.sv
// Multi-lane TMDS encoder with optional HDMI video preamble / guard-band insertion.
//   clk          pixel clock
//   resetn       synchronous active-low reset
//   de           data enable (1 = active pixel)
//   ctrl         {vsync, hsync}, sent on lane 0 while blanking
//   din          NUM_CH pixel bytes, lane i at din[8i+7:8i]
//   dout         NUM_CH TMDS symbols, lane i at dout[10i+9:10i]
//   de_out       de aligned with dout
//   short_blank  pulse on the first video cycle after a blank run shorter than the
//                preamble+guard window
// Latency is 2 cycles in DVI mode and PREAMBLE_LEN+GUARD_LEN+2 in HDMI mode.
module svo_tmds_hdmi_enc
  import svo_tmds_pkg::*;
#(
  parameter int unsigned NUM_CH       = 3,
  parameter int unsigned HDMI_MODE    = 1,
  parameter int unsigned PREAMBLE_LEN = 8,
  parameter int unsigned GUARD_LEN    = 2
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  de,
  input  logic [1:0]            ctrl,
  input  logic [NUM_CH*8-1:0]   din,
  output logic [NUM_CH*10-1:0]  dout,
  output logic                  de_out,
  output logic                  short_blank
);

  if (NUM_CH < 1) begin : g_bad_num_ch
    $error("NUM_CH must be at least 1");
  end
  if (HDMI_MODE > 1) begin : g_bad_mode
    $error("HDMI_MODE must be 0 or 1");
  end
  if ((HDMI_MODE == 1) && (NUM_CH != 3)) begin : g_bad_hdmi_lanes
    $error("HDMI mode requires NUM_CH == 3");
  end
  if ((PREAMBLE_LEN < 1) || (PREAMBLE_LEN > 8)) begin : g_bad_pre
    $error("PREAMBLE_LEN must be 1..8");
  end
  if ((GUARD_LEN < 1) || (GUARD_LEN > 2)) begin : g_bad_guard
    $error("GUARD_LEN must be 1..2");
  end

  // Classified cycle presented to the lane encoders.
  seg_e                tail_seg;
  logic [1:0]          tail_ctrl;
  logic [NUM_CH*8-1:0] tail_din;
  logic                tail_short;

  if (HDMI_MODE != 0) begin : g_hdmi
    localparam int unsigned W    = PREAMBLE_LEN + GUARD_LEN;
    localparam logic [3:0]  WCnt = 4'(W);

    // Index 0 is the newest entry, W-1 the tail being classified.
    logic [W-1:0]        de_q;
    // Marks entries holding real input rather than reset fill, so the fill
    // flushed out after reset is never mistaken for a blank run.
    logic [W-1:0]        vld_q;
    logic [1:0]          ctrl_q [W];
    logic [NUM_CH*8-1:0] din_q  [W];
    logic [3:0]          blank_cnt_d, blank_cnt_q;
    logic [W-1:0]        ahead;  // ahead[k-1]: de at distance k past the tail
    logic                guard_hit, pre_hit;

    always_ff @(posedge clk) begin
      if (!resetn) begin
        de_q        <= '0;
        vld_q       <= '0;
        blank_cnt_q <= '0;
        for (int i = 0; i < int'(W); i++) begin
          ctrl_q[i] <= 2'b00;
          din_q[i]  <= '0;
        end
      end else begin
        de_q        <= {de_q[W-2:0], de};
        vld_q       <= {vld_q[W-2:0], 1'b1};
        ctrl_q[0]   <= ctrl;
        din_q[0]    <= din;
        for (int i = 1; i < int'(W); i++) begin
          ctrl_q[i] <= ctrl_q[i-1];
          din_q[i]  <= din_q[i-1];
        end
        blank_cnt_q <= blank_cnt_d;
      end
    end

    always_comb begin
      ahead = '0;
      for (int k = 1; k < int'(W); k++) begin
        ahead[k-1] = de_q[int'(W)-1-k];
      end
      ahead[W-1] = de;  // the live input is W cycles ahead of the tail

      // Smallest k wins: any hit within GUARD_LEN makes this a guard cycle.
      guard_hit = |ahead[GUARD_LEN-1:0];
      pre_hit   = |ahead[W-1:GUARD_LEN];

      tail_ctrl = ctrl_q[W-1];
      tail_din  = din_q[W-1];
      if (de_q[W-1]) begin
        tail_seg = SEG_VIDEO;
      end else if (!vld_q[W-1]) begin
        tail_seg = SEG_CTRL;
      end else if (guard_hit) begin
        tail_seg = SEG_GUARD;
      end else if (pre_hit) begin
        tail_seg = SEG_PRE;
      end else begin
        tail_seg = SEG_CTRL;
      end

      // Length of the current blank run at the tail, saturating at W.
      blank_cnt_d = blank_cnt_q;
      if (de_q[W-1]) begin
        blank_cnt_d = '0;
      end else if (vld_q[W-1] && (blank_cnt_q != WCnt)) begin
        blank_cnt_d = blank_cnt_q + 4'd1;
      end
      tail_short = de_q[W-1] && (blank_cnt_q != 4'd0) && (blank_cnt_q < WCnt);
    end
  end else begin : g_dvi
    always_comb begin
      tail_seg   = de ? SEG_VIDEO : SEG_CTRL;
      tail_ctrl  = ctrl;
      tail_din   = din;
      tail_short = 1'b0;
    end
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_lane
    localparam logic [9:0] LaneGuard = (i == 1) ? GuardCodeL1 :
                                       (i == 2) ? GuardCodeL2 : GuardCodeL0;
    logic [1:0] lane_ctrl;

    if (i == 0) begin : g_sync
      assign lane_ctrl = tail_ctrl;
    end else if (i == 1) begin : g_ctl0
      assign lane_ctrl = (tail_seg == SEG_PRE) ? 2'b01 : 2'b00;
    end else begin : g_idle
      assign lane_ctrl = 2'b00;
    end

    svo_tmds_lane u_lane (
      .clk_i   (clk),
      .rst_ni  (resetn),
      .seg_i   (tail_seg),
      .ctrl_i  (lane_ctrl),
      .guard_i (LaneGuard),
      .data_i  (tail_din[8*i +: 8]),
      .dout_o  (dout[10*i +: 10])
    );
  end

  // Match the two encoder stages.
  logic video_s1_q, de_out_q, short_s1_q, short_blank_q;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      video_s1_q    <= 1'b0;
      de_out_q      <= 1'b0;
      short_s1_q    <= 1'b0;
      short_blank_q <= 1'b0;
    end else begin
      video_s1_q    <= (tail_seg == SEG_VIDEO);
      de_out_q      <= video_s1_q;
      short_s1_q    <= tail_short;
      short_blank_q <= short_s1_q;
    end
  end

  assign de_out      = de_out_q;
  assign short_blank = short_blank_q;

endmodule
